// File: rtl/softplus_pkg.sv
// Shared constants for the SoftPlus block sequencer: Q8.8 width, offset table,
// saturation limit and the sequencer state encoding.
package softplus_pkg;

    localparam int          Q_W       = 16;
    localparam logic [15:0] Q_MAX_POS = 16'h7FFF;

    // Offsets for non-negative operands, selected by the integer byte 0..4, then "else".
    localparam logic [15:0] OFS_P0    = 16'h004D;
    localparam logic [15:0] OFS_P1    = 16'h0037;
    localparam logic [15:0] OFS_P2    = 16'h0020;
    localparam logic [15:0] OFS_P3    = 16'h0014;
    localparam logic [15:0] OFS_P4    = 16'h000B;
    localparam logic [15:0] OFS_P_HI  = 16'h0009;

    // Offsets for negative operands, integer byte FF..FB, then "else".
    localparam logic [15:0] OFS_N1    = 16'h004C;
    localparam logic [15:0] OFS_N2    = 16'h0037;
    localparam logic [15:0] OFS_N3    = 16'h001F;
    localparam logic [15:0] OFS_N4    = 16'h000F;
    localparam logic [15:0] OFS_N5    = 16'h0007;
    localparam logic [15:0] OFS_N_LO  = 16'h0002;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/softplus_offset_lut.sv
// Combinational SoftPlus offset lookup keyed by the Q8.8 integer byte x[15:8];
// bit 7 of that byte is the operand sign.
module softplus_offset_lut
    import softplus_pkg::*;
(
    input  logic [7:0]     i_x_hi,
    output logic [Q_W-1:0] o_offset
);

    always_comb begin
        o_offset = OFS_P_HI;
        if (!i_x_hi[7]) begin
            case (i_x_hi)
                8'h00:   o_offset = OFS_P0;
                8'h01:   o_offset = OFS_P1;
                8'h02:   o_offset = OFS_P2;
                8'h03:   o_offset = OFS_P3;
                8'h04:   o_offset = OFS_P4;
                default: o_offset = OFS_P_HI;
            endcase
        end else begin
            case (i_x_hi)
                8'hFF:   o_offset = OFS_N1;
                8'hFE:   o_offset = OFS_N2;
                8'hFD:   o_offset = OFS_N3;
                8'hFC:   o_offset = OFS_N4;
                8'hFB:   o_offset = OFS_N5;
                default: o_offset = OFS_N_LO;
            endcase
        end
    end

endmodule

// File: rtl/softplus_seq_ctrl.sv
// Streams N_ELEM Q8.8 operands from a buffer through piecewise SoftPlus and writes results back.
// Optional feature macro SOFTPLUS_SAT_EN: clamp to 0x7FFF and expose a sticky sat_flag port.
module softplus_seq_ctrl
    import softplus_pkg::*;
#(
    parameter int N_ELEM = 9,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
`ifdef SOFTPLUS_SAT_EN
    output logic              sat_flag,
`endif
    output logic [1:0]        o_dbg_state
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ELEM - 1);

    state_e              r_state;
    state_e              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_v1;
    logic [ADDR_W-1:0]   r_a1;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                w_start_ok;
    logic [DATA_W-1:0]   w_base;
    logic [Q_W-1:0]      w_offset;
    logic [DATA_W-1:0]   w_result;

    // Handshake: start is a single-cycle request, accepted only in IDLE or DONE;
    // rd_data is valid exactly one cycle after rd_en, with no back-pressure on either port.
    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_READ;
            ST_READ:  if (r_addr == LAST) w_next = ST_DRAIN;
            ST_DRAIN: if (r_wr_en && r_wr_addr == LAST) w_next = ST_DONE;
            ST_DONE:  w_next = start ? ST_READ : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign rd_en       = (r_state == ST_READ);
    assign busy        = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done        = (r_state == ST_DONE);
    assign rd_addr     = r_addr;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_start_ok) begin
            r_addr <= '0;
        end else if (r_state == ST_READ && r_addr != LAST) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    softplus_offset_lut u_lut (
        .i_x_hi   (rd_data[15:8]),
        .o_offset (w_offset)
    );

    assign w_base = rd_data[15] ? '0 : rd_data;

`ifdef SOFTPLUS_SAT_EN
    logic [16:0] w_sum;
    logic        w_clamp;
    logic        r_sat;

    assign w_sum    = {1'b0, w_base} + {1'b0, w_offset};
    assign w_clamp  = (w_sum > {1'b0, Q_MAX_POS});
    assign w_result = w_clamp ? Q_MAX_POS : w_sum[15:0];
    assign sat_flag = r_sat;

    always_ff @(posedge clk) begin
        if (rst)             r_sat <= 1'b0;
        else if (w_start_ok) r_sat <= 1'b0;
        else if (r_v1 && w_clamp) r_sat <= 1'b1;
    end
`else
    // Wrap mode keeps only the low 16 bits of the sum, so the carry is never formed.
    logic [15:0] w_sum;

    assign w_sum    = w_base + w_offset;
    assign w_result = w_sum;
`endif

    // Two-stage pipeline: read strobe -> data arrives -> result registered onto wr_*.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_a1      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_v1    <= rd_en;
            r_a1    <= r_addr;
            r_wr_en <= r_v1;
            if (r_v1) begin
                r_wr_addr <= r_a1;
                r_wr_data <= w_result;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_softplus_seq_ctrl.sv
// Directed bench for softplus_seq_ctrl: a 9-element instance for block runs and
// a 1-element instance for single-operand arithmetic and minimum-length timing.
module tb_softplus_seq_ctrl;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y_wrap;
        logic [15:0] y_sat;
        logic        sat;
    } one_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_1;

    logic        busy, done, rd_en, wr_en;
    logic [3:0]  rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic [1:0]  dbg;

    logic        busy_1, done_1, rd_en_1, wr_en_1;
    logic [3:0]  rd_addr_1, wr_addr_1;
    logic [15:0] rd_data_1, wr_data_1;
    logic [1:0]  dbg_1;
`ifdef SOFTPLUS_SAT_EN
    logic        sat_flag, sat_flag_1;
`endif

    logic [15:0] mem9 [16];
    logic [15:0] mem1 [16];
    logic [15:0] exp_q [$];

    vec_t vecs [9];
    one_t ones [4];

    int checks = 0;
    int errors = 0;

    softplus_seq_ctrl #(.N_ELEM(9), .ADDR_W(4), .DATA_W(16)) u_dut9 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef SOFTPLUS_SAT_EN
        .sat_flag    (sat_flag),
`endif
        .o_dbg_state (dbg)
    );

    softplus_seq_ctrl #(.N_ELEM(1), .ADDR_W(4), .DATA_W(16)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .start       (start_1),
        .busy        (busy_1),
        .done        (done_1),
        .rd_en       (rd_en_1),
        .rd_addr     (rd_addr_1),
        .rd_data     (rd_data_1),
        .wr_en       (wr_en_1),
        .wr_addr     (wr_addr_1),
        .wr_data     (wr_data_1),
`ifdef SOFTPLUS_SAT_EN
        .sat_flag    (sat_flag_1),
`endif
        .o_dbg_state (dbg_1)
    );

    // Clock and buffer models: read data appears exactly one cycle after rd_en.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data   <= rd_en   ? mem9[rd_addr]   : 16'hDEAD;
        rd_data_1 <= rd_en_1 ? mem1[rd_addr_1] : 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle c is the cycle in which start is first high; outputs are sampled mid-cycle.
    task automatic run_main(input bit noise, input bit chain, input int rst_c, input int n_cyc);
        int r;
        bit aborted, e_rd, e_wr, e_busy, e_done;
        int wr_cnt, done_cnt, exp_wr_cnt, exp_done_cnt;
        logic [15:0] e_data;
        wr_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            r       = (chain && c >= 12) ? c - 12 : c;
            aborted = (rst_c >= 0) && (c > rst_c);
            e_rd    = !aborted && r >= 1 && r <= 9;
            e_wr    = !aborted && r >= 3 && r <= 11;
            e_busy  = !aborted && r >= 1 && r <= 11;
            e_done  = !aborted && (c == 12 || (chain && c == 24));
            check($sformatf("rd_en c%0d", c), 32'(rd_en), 32'(e_rd));
            check($sformatf("busy c%0d", c), 32'(busy), 32'(e_busy));
            check($sformatf("wr_en c%0d", c), 32'(wr_en), 32'(e_wr));
            check($sformatf("done c%0d", c), 32'(done), 32'(e_done));
            if (e_rd) check($sformatf("rd_addr c%0d", c), 32'(rd_addr), 32'(r - 1));
            if (e_wr) begin
                e_data = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
                check($sformatf("wr_addr c%0d", c), 32'(wr_addr), 32'(r - 3));
                check($sformatf("wr_data c%0d", c), 32'(wr_data), 32'(e_data));
            end
            if (aborted) begin
                check($sformatf("rst rd_addr c%0d", c), 32'(rd_addr), 32'd0);
                check($sformatf("rst wr_addr c%0d", c), 32'(wr_addr), 32'd0);
                check($sformatf("rst wr_data c%0d", c), 32'(wr_data), 32'd0);
                check($sformatf("rst state c%0d", c), 32'(dbg), 32'd0);
            end
            wr_cnt   += int'(wr_en);
            done_cnt += int'(done);
            start = (c == 0) || (noise && (c == 4 || c == 7)) || (chain && c == 12);
            rst   = (c == rst_c);
        end
        start = 1'b0;
        rst   = 1'b0;
        exp_wr_cnt   = (rst_c >= 0) ? rst_c - 2 : (chain ? 18 : 9);
        exp_done_cnt = (rst_c >= 0) ? 0 : (chain ? 2 : 1);
        check("write count", 32'(wr_cnt), 32'(exp_wr_cnt));
        check("done count", 32'(done_cnt), 32'(exp_done_cnt));
    endtask

    task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic sat);
        mem1[0] = x;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("n1 rd_en c%0d", c), 32'(rd_en_1), 32'(c == 1));
            check($sformatf("n1 busy c%0d", c), 32'(busy_1), 32'(c >= 1 && c <= 3));
            check($sformatf("n1 wr_en c%0d", c), 32'(wr_en_1), 32'(c == 3));
            check($sformatf("n1 done c%0d", c), 32'(done_1), 32'(c == 4));
            if (c == 1) check("n1 rd_addr", 32'(rd_addr_1), 32'd0);
            if (c == 3) begin
                check($sformatf("n1 wr_data x=%h", x), 32'(wr_data_1), 32'(y));
                check("n1 wr_addr", 32'(wr_addr_1), 32'd0);
            end
`ifdef SOFTPLUS_SAT_EN
            if (c == 4) check($sformatf("n1 sat_flag x=%h", x), 32'(sat_flag_1), 32'(sat));
`else
            if (c == 4) check($sformatf("n1 sat unused x=%h", x), 32'(sat), 32'(sat));
`endif
            start_1 = (c == 0);
        end
        start_1 = 1'b0;
    endtask

    task automatic push_block();
        for (int k = 0; k < 9; k++) exp_q.push_back(vecs[k].y);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h004D};
        vecs[1] = '{16'h0180, 16'h01B7};
        vecs[2] = '{16'hFF80, 16'h004C};
        vecs[3] = '{16'h0400, 16'h040B};
        vecs[4] = '{16'hFB00, 16'h0007};
        vecs[5] = '{16'h0A00, 16'h0A09};
        vecs[6] = '{16'h8000, 16'h0002};
        vecs[7] = '{16'h0100, 16'h0137};
        vecs[8] = '{16'hFF00, 16'h004C};
        ones[0] = '{16'hFE40, 16'h0037, 16'h0037, 1'b0};
        ones[1] = '{16'h7FFC, 16'h8005, 16'h7FFF, 1'b1};
        ones[2] = '{16'h0500, 16'h0509, 16'h0509, 1'b0};
        ones[3] = '{16'h8000, 16'h0002, 16'h0002, 1'b0};
        for (int k = 0; k < 16; k++) begin
            mem9[k] = (k < 9) ? vecs[k].x : 16'h0000;
            mem1[k] = 16'h0000;
        end

        rst = 1'b1;
        start = 1'b0;
        start_1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rd_en", 32'(rd_en), 32'd0);
        check("reset rd_addr", 32'(rd_addr), 32'd0);
        check("reset wr_en", 32'(wr_en), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        check("reset state", 32'(dbg), 32'd0);
        check("reset n1 state", 32'(dbg_1), 32'd0);
`ifdef SOFTPLUS_SAT_EN
        check("reset sat_flag", 32'(sat_flag), 32'd0);
`endif
        rst = 1'b0;

        // Full block with start re-pulsed at cycles 4 and 7.
        push_block();
        run_main(1'b1, 1'b0, -1, 14);

        // Start in the done cycle launches a back-to-back second run.
        push_block();
        push_block();
        run_main(1'b0, 1'b1, -1, 26);

        // Reset in cycle 5 aborts the run; a fresh run afterwards is complete.
        push_block();
        run_main(1'b0, 1'b0, 5, 14);
        exp_q.delete();
        push_block();
        run_main(1'b0, 1'b0, -1, 14);

        for (int i = 0; i < 4; i++) begin
`ifdef SOFTPLUS_SAT_EN
            run_one(ones[i].x, ones[i].y_sat, ones[i].sat);
`else
            run_one(ones[i].x, ones[i].y_wrap, ones[i].sat);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
